// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: decoder ALU control
// codes and FSM state encodings.
package muldiv_unit_pkg;

    localparam logic [4:0] ALU_MUL  = 5'd16;
    localparam logic [4:0] ALU_MULU = 5'd17;
    localparam logic [4:0] ALU_DIV  = 5'd18;
    localparam logic [4:0] ALU_DIVU = 5'd19;
    localparam logic [4:0] ALU_MFHI = 5'd20;
    localparam logic [4:0] ALU_MFLO = 5'd21;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;

    function automatic logic is_md_op(input logic [4:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_MULU) ||
               (ctrl == ALU_DIV) || (ctrl == ALU_DIVU);
    endfunction

    function automatic logic is_mf_op(input logic [4:0] ctrl);
        return (ctrl == ALU_MFHI) || (ctrl == ALU_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a
// 2*WIDTH accumulator ({upper, lower} = {partial/remainder, multiplier/quotient}).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Remainder shifted left with the next dividend bit; top bit of diff is the borrow.
        shifted = acc_i[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, operand_i};
        if (div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with MFHI/MFLO read-back and stall.
// Define MULDIV_FAST_MUL_EN to compute MUL/MULU with a single-cycle product.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op, op_div, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b, quot, rem;
    logic [2*WIDTH-1:0] step_acc, product;

    assign signed_op = (alu_ctrl == ALU_MUL) || (alu_ctrl == ALU_DIV);
    assign op_div    = (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_DIVU);
    assign sign_a    = signed_op && src_a[WIDTH-1];
    assign sign_b    = signed_op && src_b[WIDTH-1];
    assign mag_a     = sign_a ? -src_a : src_a;
    assign mag_b     = sign_b ? -src_b : src_b;

    // Signs were stripped at launch; restore them on the finished magnitudes.
    assign product = neg_q_q ? -acc_q : acc_q;
    assign quot    = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem     = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i     (is_div_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    always_comb begin
        // NOTE: every next-state signal takes its current value first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start && is_md_op(alu_ctrl)) begin
                    is_div_d = op_div;
                    acc_d    = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                    opnd_d   = op_div ? mag_b : mag_a;
                    neg_q_d  = sign_a ^ sign_b;
                    neg_r_d  = sign_a;
                    dbz_d    = op_div && (src_b == '0);
                    cnt_d    = '0;
                    state_d  = MD_CALC;
                end
            end
            MD_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
                if (!is_div_q) begin
                    acc_d   = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
                    state_d = MD_FIX;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = MD_FIX;
                end
`else
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = MD_FIX;
`endif
            end
            MD_FIX: begin
                if (is_div_q) begin
                    lo_d = dbz_q ? '1 : quot;
                    hi_d = rem;
                end else begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q != MD_IDLE);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign stall   = is_mf_op(alu_ctrl) && busy;
    assign rd_data = (alu_ctrl == ALU_MFHI) ? hi_q :
                     (alu_ctrl == ALU_MFLO) ? lo_q : '0;

endmodule
